// File: rtl/mul_multicycle_if.sv
// Handshake and operand bundle between the EX stage and the iterative multiplier.
// The pipeline side is the master; the multiplier is the slave.
interface mul_multicycle_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_mul_i;
  logic [1:0]         mode_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] acc_i;
  logic               busy_o;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output start_i, annul_i, signed_mul_i, mode_i, opdata1_i, opdata2_i, acc_i,
    input  busy_o, result_o, ready_o
  );

  modport slave (
    input  start_i, annul_i, signed_mul_i, mode_i, opdata1_i, opdata2_i, acc_i,
    output busy_o, result_o, ready_o
  );
endinterface

// File: rtl/mul_multicycle.sv
// Iterative sign-magnitude multiplier retiring STEP multiplier bits per cycle,
// with optional accumulate (MADD) or subtract-from-accumulator (MSUB).
//
// state | meaning
// IDLE  | waiting for start_i without annul_i; operands captured on accept
// CALC  | shift-add, STEP bits per cycle, N = WIDTH/STEP cycles
// SIGN  | negate the magnitude product when the operand signs differ
// ACC   | fold the accumulator in according to mode; raise ready_o
// DONE  | hold result while start_i stays high
module mul_multicycle #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  mul_multicycle_if.slave  bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W  = 1;
  localparam logic [W2-1:0]    ONE_W2 = 1;

  typedef enum logic [2:0] {IDLE, CALC, SIGN, ACC, DONE} state_t;

  state_t            state, state_nxt;
  logic [W2-1:0]     mcand, product, acc, result;
  logic [WIDTH-1:0]  mplier;
  logic [1:0]        mode;
  logic              neg, ready;
  logic [CW-1:0]     cnt;

  logic              accept, op_zero, calc_last;
  logic [WIDTH-1:0]  mag1, mag2;
  logic [W2-1:0]     partial, acc_sum;

  assign accept    = bus.start_i & ~bus.annul_i;
  assign op_zero   = (bus.opdata1_i == '0) | (bus.opdata2_i == '0);
  assign calc_last = (cnt == CW'(N - 1));

  // Two's complement of the most negative value still fits as an unsigned magnitude.
  assign mag1 = (bus.signed_mul_i & bus.opdata1_i[WIDTH-1]) ? (~bus.opdata1_i + ONE_W) : bus.opdata1_i;
  assign mag2 = (bus.signed_mul_i & bus.opdata2_i[WIDTH-1]) ? (~bus.opdata2_i + ONE_W) : bus.opdata2_i;

  assign partial = mcand * W2'(mplier[STEP-1:0]);

  always_comb begin
    case (mode)
      2'b01:   acc_sum = acc + product;
      2'b10:   acc_sum = acc - product;
      default: acc_sum = product;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op_zero ? ACC : CALC;
      CALC: begin
        if (bus.annul_i)     state_nxt = IDLE;
        else if (calc_last)  state_nxt = SIGN;
      end
      SIGN: state_nxt = bus.annul_i ? IDLE : ACC;
      ACC:  state_nxt = bus.annul_i ? IDLE : DONE;
      DONE: if (!bus.start_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      acc     <= '0;
      mode    <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready  <= 1'b0;
          result <= '0;
          if (accept) begin
            mcand   <= W2'(mag1);
            mplier  <= mag2;
            neg     <= bus.signed_mul_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            mode    <= bus.mode_i;
            acc     <= bus.acc_i;
            product <= '0;
            cnt     <= '0;
          end
        end
        CALC: if (!bus.annul_i) begin
          product <= product + partial;
          mcand   <= mcand << STEP;
          mplier  <= mplier >> STEP;
          cnt     <= cnt + CW'(1);
        end
        SIGN: if (!bus.annul_i && neg) product <= ~product + ONE_W2;
        ACC: if (!bus.annul_i) begin
          result <= acc_sum;
          ready  <= 1'b1;
        end
        DONE: if (!bus.start_i) begin
          ready  <= 1'b0;
          result <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = (state == CALC) | (state == SIGN) | (state == ACC);
  assign bus.result_o = result;
  assign bus.ready_o  = ready;
endmodule

// File: tb/tb_mul_multicycle.sv
// Drives three multipliers (STEP 1, 2, 4) with identical stimulus and checks
// result, latency and busy against a plain-arithmetic reference.
module tb_mul_multicycle;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, annul, sg;
  logic [1:0]  md;
  logic [31:0] op1, op2;
  logic [63:0] ac;

  logic        rdy [3];
  logic        bsy [3];
  logic [63:0] res [3];
  int          steps [3] = '{1, 2, 4};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_multicycle_if #(.WIDTH(32)) if1 ();
  mul_multicycle_if #(.WIDTH(32)) if2 ();
  mul_multicycle_if #(.WIDTH(32)) if4 ();

  mul_multicycle #(.WIDTH(32), .STEP(1)) u_s1 (.clk(clk), .rst(rst), .bus(if1));
  mul_multicycle #(.WIDTH(32), .STEP(2)) u_s2 (.clk(clk), .rst(rst), .bus(if2));
  mul_multicycle #(.WIDTH(32), .STEP(4)) u_s4 (.clk(clk), .rst(rst), .bus(if4));

  assign if1.start_i = start;  assign if2.start_i = start;  assign if4.start_i = start;
  assign if1.annul_i = annul;  assign if2.annul_i = annul;  assign if4.annul_i = annul;
  assign if1.signed_mul_i = sg; assign if2.signed_mul_i = sg; assign if4.signed_mul_i = sg;
  assign if1.mode_i = md;      assign if2.mode_i = md;      assign if4.mode_i = md;
  assign if1.opdata1_i = op1;  assign if2.opdata1_i = op1;  assign if4.opdata1_i = op1;
  assign if1.opdata2_i = op2;  assign if2.opdata2_i = op2;  assign if4.opdata2_i = op2;
  assign if1.acc_i = ac;       assign if2.acc_i = ac;       assign if4.acc_i = ac;

  assign rdy[0] = if1.ready_o; assign rdy[1] = if2.ready_o; assign rdy[2] = if4.ready_o;
  assign bsy[0] = if1.busy_o;  assign bsy[1] = if2.busy_o;  assign bsy[2] = if4.busy_o;
  assign res[0] = if1.result_o; assign res[1] = if2.result_o; assign res[2] = if4.result_o;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [1:0] m,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] acc_v);
    longint sa, sb;
    logic [63:0] p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    case (m)
      2'b01:   return acc_v + p;
      2'b10:   return acc_v - p;
      default: return p;
    endcase
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble_inputs();
    op1 = $urandom;
    op2 = $urandom;
    ac  = {$urandom, $urandom};
    md  = 2'($urandom_range(0, 3));
    sg  = 1'($urandom_range(0, 1));
  endtask

  // One full operation, start held through DONE until every instance has finished.
  task automatic run_op(input string tag, input logic s, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc_v, input logic [63:0] exp);
    int lat [3];
    bit zero;
    zero = (a == 0) || (b == 0);
    for (int d = 0; d < 3; d++) lat[d] = zero ? 2 : (32 / steps[d]) + 3;
    @(negedge clk);
    sg = s; md = m; op1 = a; op2 = b; ac = acc_v; annul = 1'b0; start = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      if (k == 1) scramble_inputs();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("%s rdy s%0d e%0d", tag, steps[d], k), 64'(rdy[d]), 64'(k >= lat[d]));
        chk($sformatf("%s busy s%0d e%0d", tag, steps[d], k), 64'(bsy[d]), 64'(k < lat[d]));
      end
    end
    for (int d = 0; d < 3; d++) chk($sformatf("%s res s%0d", tag, steps[d]), res[d], exp);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s drop rdy s%0d", tag, steps[d]), 64'(rdy[d]), 64'h0);
      chk($sformatf("%s drop res s%0d", tag, steps[d]), res[d], 64'h0);
    end
  endtask

  initial begin
    logic s_r;
    logic [1:0] m_r;
    logic [31:0] a_r, b_r;
    logic [63:0] acc_r;

    start = 1'b0; annul = 1'b0; sg = 1'b0; md = 2'b00;
    op1 = '0; op2 = '0; ac = '0;
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset rdy s%0d", steps[d]), 64'(rdy[d]), 64'h0);
      chk($sformatf("reset res s%0d", steps[d]), res[d], 64'h0);
      chk($sformatf("reset busy s%0d", steps[d]), 64'(bsy[d]), 64'h0);
    end
    @(negedge clk) rst = 1'b1;

    run_op("ffxff",     1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001);
    run_op("m3x7",      1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7,         64'h0, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("minxmin",   1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000);
    run_op("u80x2",     1'b0, 2'b00, 32'h8000_0000, 32'd2,         64'h0, 64'h0000_0001_0000_0000);
    run_op("zero",      1'b0, 2'b00, 32'h0,         32'h1234,      64'h0, 64'h0);
    run_op("madd_zero", 1'b0, 2'b01, 32'h9,         32'h0,         64'h55, 64'h55);
    run_op("msub",      1'b0, 2'b10, 32'd6,         32'd7,         64'd100, 64'h3A);
    run_op("madd_neg",  1'b1, 2'b01, 32'hFFFF_FFFF, 32'd1,         64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("madd_wrap", 1'b0, 2'b01, 32'd1,         32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    run_op("mode11",    1'b0, 2'b11, 32'd3,         32'd5,         64'd7, 64'd15);

    // Annul during CALC cycle 5, then confirm no result ever appears.
    @(negedge clk);
    sg = 1'b0; md = 2'b00; op1 = 32'h1234_5678; op2 = 32'h0BAD_F00D; start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) annul = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) chk($sformatf("annul busy s%0d", steps[d]), 64'(bsy[d]), 64'h0);
    @(negedge clk) annul = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) chk($sformatf("annul rdy s%0d c%0d", steps[d], k), 64'(rdy[d]), 64'h0);
    end
    run_op("reissue", 1'b0, 2'b00, 32'h1234_5678, 32'h0BAD_F00D, 64'h0,
           ref_mul(1'b0, 2'b00, 32'h1234_5678, 32'h0BAD_F00D, 64'h0));

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    op1 = 32'hDEAD_BEEF; op2 = 32'h0000_0777; start = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst calc busy s%0d", steps[d]), 64'(bsy[d]), 64'h0);
      chk($sformatf("rst calc rdy s%0d", steps[d]), 64'(rdy[d]), 64'h0);
    end
    @(negedge clk) begin rst = 1'b1; start = 1'b0; end

    // Asynchronous reset while a result is held in DONE.
    @(negedge clk);
    sg = 1'b0; md = 2'b00; op1 = 32'd5; op2 = 32'd7; start = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("held res s%0d", steps[d]), res[d], 64'd35);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst done res s%0d", steps[d]), res[d], 64'h0);
      chk($sformatf("rst done rdy s%0d", steps[d]), 64'(rdy[d]), 64'h0);
    end
    @(negedge clk) begin rst = 1'b1; start = 1'b0; end

    for (int i = 0; i < 40; i++) begin
      s_r   = 1'($urandom_range(0, 1));
      m_r   = 2'($urandom_range(0, 3));
      a_r   = pick_op();
      b_r   = pick_op();
      acc_r = {$urandom, $urandom};
      run_op($sformatf("rnd%0d", i), s_r, m_r, a_r, b_r, acc_r, ref_mul(s_r, m_r, a_r, b_r, acc_r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_multicycle.md
Name: mul_multicycle

Overview:
Parametrised iterative multiplier, successor to the 32-bit shift-add multiplier in the execute stage. Adds configurable operand width and bits retired per cycle, plus MUL/MADD/MSUB modes that fold an accumulator (HI/LO pair) into the result. Operands are captured at accept, so the pipeline may change its inputs afterwards. Sits beside the divider under EX stall control. Uses the same start/annul/ready handshake.

Parameters:
WIDTH, 32, operand width. result_o is 2*WIDTH.
STEP, 2, multiplier bits retired per CALC cycle. Legal values: 1, 2, 4. Must divide WIDTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset.
start_i  in  1  request. Sampled in IDLE and DONE.
annul_i  in  1  cancel current operation. Also blocks accept.
signed_mul_i  in  1  1 = two's-complement operands.
mode_i  in  2  00 MUL, 01 MADD (acc+prod), 10 MSUB (acc-prod), 11 treated as MUL.
opdata1_i  in  WIDTH  multiplicand.
opdata2_i  in  WIDTH  multiplier.
acc_i  in  2*WIDTH  accumulator. Captured at accept.
busy_o  out  1  high in CALC/SIGN/ACC. Combinational from state.
result_o  out  2*WIDTH  final value. Valid while ready_o=1.
ready_o  out  1  result valid.

Behaviour:
- Reset (rst=0, async): state=IDLE, result_o=0, ready_o=0, cnt=0, internal registers=0. Reset mid-operation aborts with no ready pulse.
- States: IDLE, CALC, SIGN, ACC, DONE. Let N = WIDTH/STEP.
- IDLE, accept condition start_i=1 and annul_i=0:
  - Latch |opdata1_i| and |opdata2_i|. Take the absolute value only when signed_mul_i=1 and the MSB is 1; otherwise use the raw value.
  - Latch neg = signed_mul_i & (op1 MSB ^ op2 MSB), mode_i, acc_i. Clear product and cnt.
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1). It must be held unsigned in WIDTH bits without overflow.
  - If either operand is 0: product=0, go to ACC (skip CALC/SIGN).
  - Otherwise go to CALC.
  - With no accept: ready_o=0, result_o=0.
- CALC: each cycle:
  - product += mcand * mplier[STEP-1:0], where mcand is 2*WIDTH bits zero-extended.
  - mcand <<= STEP; mplier >>= STEP; cnt++.
  - After the N-th CALC cycle, go to SIGN.
- SIGN: product = neg ? (~product+1) : product. Go to ACC.
- ACC:
  - MADD: result_o <= acc + product. MSUB: result_o <= acc - product. MUL/11: result_o <= product.
  - All arithmetic is modulo 2^(2*WIDTH); no overflow flag.
  - ready_o <= 1. Go to DONE.
- DONE:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0: go to IDLE, ready_o<=0, result_o<=0.
  - A new op needs start_i low for at least one cycle after ready.
  - annul_i is ignored in DONE.
- Annul: annul_i=1 in CALC, SIGN or ACC forces IDLE on the next edge. ready_o stays 0 and result_o is unchanged (0).
- Latency, counting the accepting edge as edge 1: ready_o is high after edge N+3 for nonzero operands, and after edge 2 for a zero operand.
  - Examples: WIDTH=32: STEP=2 → 19, STEP=1 → 35, STEP=4 → 11.
- Input changes after accept must not affect the result.
- busy_o=0 in IDLE and DONE.

Test Plan:
1. Unsigned 0xFFFFFFFF*0xFFFFFFFF, MUL, STEP=2 -> result_o=0xFFFFFFFE00000001; ready_o rises after edge 19; busy_o high edges 1-18.
2. Signed 0xFFFFFFFD(-3)*7, MUL -> 0xFFFFFFFFFFFFFFEB. Signed 0x80000000*0x80000000 -> 0x4000000000000000. Unsigned 0x80000000*2 -> 0x0000000100000000.
3. Zero operand: 0*0x1234 MUL -> result 0, ready after edge 2. MADD with opdata2=0 and acc=0x55 -> 0x55.
4. MSUB acc=100, 6*7 unsigned -> 0x3A. MADD signed acc=0, 0xFFFFFFFF*1 -> 0xFFFFFFFFFFFFFFFF. MADD acc=0xFFFFFFFFFFFFFFFF, 1*1 -> 0 (wrap).
5. annul_i pulsed at CALC cycle 5 -> IDLE next edge, ready_o never rises; re-issue completes normally. rst low mid-CALC -> result_o=0, ready_o=0 immediately, without a clock edge.
6. Hold start_i high through DONE -> result held. Drop start_i -> ready_o=0 next edge. Change opdata*_i during CALC -> result unchanged. Repeat test 1 with STEP=1 and STEP=4 -> latency 35 and 11.
